// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: start/ir/mem_rdy in, Datapath control words out.
// master drives the sequencer; slave is the sequencer itself.
interface alu_ctrl_seq_if;
   logic        start;
   logic [31:0] ir;
   logic        mem_rdy;
   logic [31:0] enable;
   logic [31:0] busSelect;
   logic        MD_Read;
   logic        IncPC;
   logic [3:0]  Control_Signals;
   logic        busy;
   logic        done;
   logic        illegal;

   modport master (
      output start, ir, mem_rdy,
      input  enable, busSelect, MD_Read, IncPC,
      input  Control_Signals, busy, done, illegal
   );

   modport slave (
      input  start, ir, mem_rdy,
      output enable, busSelect, MD_Read, IncPC,
      output Control_Signals, busy, done, illegal
   );
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: hardwired fetch/execute control sequencer.
// Moore FSM; outputs decode from state and the IR fields.
module alu_ctrl_seq (
   input  logic         clk,
   input  logic         clr,
   alu_ctrl_seq_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_T0, S_T1, S_T2,
      S_T3, S_T4, S_T5, S_T6
   } state_e;

   state_e state_q, state_d;

   logic [4:0] op;
   logic [3:0] ra, rb, rc;
   logic       legal, is_md, is_un;

   assign op    = bus.ir[31:27];
   assign ra    = bus.ir[26:23];
   assign rb    = bus.ir[22:19];
   assign rc    = bus.ir[18:15];
   assign legal = ~op[4];
   assign is_md = legal & (op[3:1] == 3'b110);
   assign is_un = legal & (op[3:1] == 3'b111);

   logic [31:0] en, bs;
   logic [3:0]  cs;
   logic        mdr, inc, dn, ill;

   // State register; clr drops straight back to IDLE.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state sequencing, with memory wait in T1.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (bus.start) state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1:   if (bus.mem_rdy) state_d = S_T2;
         S_T2:   state_d = S_T3;
         S_T3:   state_d = legal ? S_T4 : S_IDLE;
         S_T4:   state_d = S_T5;
         S_T5:   state_d = is_md ? S_T6 : S_IDLE;
         S_T6:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control word for the current step.
   always_comb begin
      en  = '0;
      bs  = '0;
      cs  = '0;
      mdr = 1'b0;
      inc = 1'b0;
      dn  = 1'b0;
      ill = 1'b0;
      unique case (state_q)
         S_IDLE: ;
         S_T0: begin
            bs  = 32'h0010_0000;
            en  = 32'h0210_0000;
            inc = 1'b1;
         end
         S_T1: begin
            mdr = 1'b1;
            en  = 32'h0020_0000;
         end
         S_T2: begin
            bs = 32'h0020_0000;
            en = 32'h0080_0000;
         end
         S_T3: begin
            if (legal) begin
               bs = 32'd1 << rb;
               en = 32'h0800_0000;
            end else begin
               ill = 1'b1;
            end
         end
         S_T4: begin
            en = 32'h0100_0000;
            cs = op[3:0];
            bs = is_un ? (32'd1 << rb) : (32'd1 << rc);
         end
         S_T5: begin
            bs = 32'h0008_0000;
            if (is_md) begin
               en = 32'h0002_0000;
            end else begin
               en = 32'd1 << ra;
               dn = 1'b1;
            end
         end
         S_T6: begin
            bs = 32'h0004_0000;
            en = 32'h0001_0000;
            dn = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.enable          = en;
   assign bus.busSelect       = bs;
   assign bus.MD_Read         = mdr;
   assign bus.IncPC           = inc;
   assign bus.Control_Signals = cs;
   assign bus.busy            = (state_q != S_IDLE);
   assign bus.done            = dn;
   assign bus.illegal         = ill;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed and random fetch/execute runs
// compared cycle by cycle against an expected control-word list.
module tb_alu_ctrl_seq;

   logic clk;
   logic clr;

   alu_ctrl_seq_if u_if ();

   alu_ctrl_seq dut (
      .clk (clk),
      .clr (clr),
      .bus (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] en;
      logic [31:0] bs;
      logic        mdr;
      logic        inc;
      logic [3:0]  cs;
      logic        busy;
      logic        dn;
      logic        ill;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk;
   int   n_err;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic chk_word(input string tag, input exp_t e);
      chk({tag, ".en"},   u_if.enable,    e.en);
      chk({tag, ".bs"},   u_if.busSelect, e.bs);
      chk({tag, ".mdr"},  32'(u_if.MD_Read), 32'(e.mdr));
      chk({tag, ".inc"},  32'(u_if.IncPC),   32'(e.inc));
      chk({tag, ".cs"},   32'(u_if.Control_Signals), 32'(e.cs));
      chk({tag, ".busy"}, 32'(u_if.busy),    32'(e.busy));
      chk({tag, ".done"}, 32'(u_if.done),    32'(e.dn));
      chk({tag, ".ill"},  32'(u_if.illegal), 32'(e.ill));
      chk({tag, ".bs1h"}, 32'($countones(u_if.busSelect) <= 1), 32'd1);
   endtask

   task automatic chk_zero(input string tag);
      exp_t z;
      z = '0;
      chk_word(tag, z);
   endtask

   function automatic exp_t step(input int en_bit,
                                 input int bs_bit);
      exp_t e;
      e = '0;
      e.busy = 1'b1;
      if (en_bit >= 0) e.en = 32'd1 << en_bit;
      if (bs_bit >= 0) e.bs = 32'd1 << bs_bit;
      return e;
   endfunction

   // Expected cycle list from T0 to the final step.
   task automatic build(input logic [31:0] irv, input int w);
      exp_t e;
      int op, ra, rb, rc;
      op = int'(irv[31:27]);
      ra = int'(irv[26:23]);
      rb = int'(irv[22:19]);
      rc = int'(irv[18:15]);
      exp_q.delete();
      e = step(25, 20);
      e.en[20] = 1'b1;
      e.inc = 1'b1;
      exp_q.push_back(e);
      for (int i = 0; i <= w; i++) begin
         e = step(21, -1);
         e.mdr = 1'b1;
         exp_q.push_back(e);
      end
      exp_q.push_back(step(23, 21));
      if (op >= 16) begin
         e = step(-1, -1);
         e.ill = 1'b1;
         exp_q.push_back(e);
         return;
      end
      exp_q.push_back(step(27, rb));
      e = step(24, (op == 14 || op == 15) ? rb : rc);
      e.cs = 4'(op);
      exp_q.push_back(e);
      if (op == 12 || op == 13) begin
         exp_q.push_back(step(17, 19));
         e = step(16, 18);
         e.dn = 1'b1;
         exp_q.push_back(e);
      end else begin
         e = step(ra, 19);
         e.dn = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   // Starts from an IDLE cycle; ends in an IDLE cycle.
   task automatic run_txn(input string name,
                          input logic [31:0] irv,
                          input int w,
                          input int abort_k);
      build(irv, w);
      u_if.start   = 1'b1;
      u_if.ir      = $urandom;
      u_if.mem_rdy = 1'($urandom);
      for (int k = 0; k < exp_q.size(); k++) begin
         @(posedge clk);
         #1;
         chk_word($sformatf("%s.c%0d", name, k), exp_q[k]);
         u_if.start = 1'($urandom);
         if (k >= 1 && k <= w + 1)
            u_if.mem_rdy = (k == w + 1);
         else
            u_if.mem_rdy = 1'($urandom);
         if (k < w + 2) u_if.ir = $urandom;
         else           u_if.ir = irv;
         if (k == abort_k) begin
            #2 clr = 1'b0;
            #1 chk_zero({name, ".abort"});
            @(posedge clk);
            #1 chk_zero({name, ".abort_hold"});
            clr = 1'b1;
            u_if.start = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1 chk_zero({name, ".idle"});
      u_if.start = 1'b0;
   endtask

   function automatic logic [31:0] mk_ir(input int op,
                                         input int ra,
                                         input int rb,
                                         input int rc);
      logic [14:0] lo;
      lo = 15'($urandom);
      return {5'(op), 4'(ra), 4'(rb), 4'(rc), lo};
   endfunction

   initial begin
      n_chk = 0;
      n_err = 0;
      clr = 1'b0;
      u_if.start = 1'b0;
      u_if.ir = '0;
      u_if.mem_rdy = 1'b0;

      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         u_if.start = 1'($urandom);
         u_if.ir = $urandom;
         u_if.mem_rdy = 1'($urandom);
         #1 chk_zero($sformatf("rst%0d", i));
      end
      clr = 1'b1;

      run_txn("rol", 32'h509A8000, 0, -1);
      run_txn("shr_wait", 32'h389A8000, 3, -1);
      run_txn("mul", mk_ir(12, 7, 2, 4), 0, -1);
      run_txn("div", mk_ir(13, 0, 9, 9), 1, -1);
      run_txn("neg", mk_ir(14, 0, 6, 11), 0, -1);
      run_txn("ill", mk_ir(20, 1, 2, 3), 0, -1);
      run_txn("abort", 32'h509A8000, 0, 4);
      run_txn("post_abort", 32'h509A8000, 0, -1);

      for (int t = 0; t < 40; t++) begin
         int op;
         op = $urandom_range(0, 19);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk);
               #1 chk_zero($sformatf("gap%0d", t));
            end
         end
         run_txn($sformatf("rnd%0d", t),
                 mk_ir(op, $urandom_range(0, 15),
                       $urandom_range(0, 15),
                       $urandom_range(0, 15)),
                 $urandom_range(0, 3), -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Hardwired control sequencer that drives the Phase-1 `Datapath` control inputs: `enable`, `busSelect`, `MD_Read`, `IncPC` and `Control_Signals`. It runs the fetch steps T0–T2, then the execute steps T3–T5 (plus T6 for mul/div) for register-format ALU instructions. It decodes the instruction from the IR output and handshakes with memory on the MDR read. It replaces hand-sequenced control words in benches and becomes the upstream controller of `Datapath`.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `clr`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin one fetch/execute; sampled only in IDLE.
- `ir`  in  32  IR register contents. Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- `mem_rdy`  in  1  memory data valid on `MDataIn`; sampled in T1.
- `enable`  out  32  register load enables. Rn=[n] (0–15), HI=[16], LO=[17], PC=[20], MDR=[21], IR=[23], Z=[24], MAR=[25], Y=[27].
- `busSelect`  out  32  bus driver selects. Rn=[n], Zhigh=[18], Zlow=[19], PC=[20], MDR=[21].
- `MD_Read`  out  1  MDR input mux selects memory.
- `IncPC`  out  1  PC increment.
- `Control_Signals`  out  4  ALU op code.
- `busy`  out  1  high in T0–T6.
- `done`  out  1  one-cycle pulse in the final execute state.
- `illegal`  out  1  one-cycle pulse in T3 on an undecodable opcode.

## Operation
- Moore FSM with states IDLE, T0, T1, T2, T3, T4, T5, T6. All outputs decode from the state register and `ir`. Outputs not listed for a state are 0.
- IDLE: all outputs 0. If `start`=1, go to T0.
- T0: busSelect[20], enable[25], enable[20], IncPC. Go to T1.
- T1: MD_Read, enable[21]. Stay in T1 while `mem_rdy`=0; go to T2 on the edge where `mem_rdy`=1.
- T2: busSelect[21], enable[23]. Go to T3.
- Opcode classes (decoded from `ir` in T3–T6):
  - 0–11: binary ALU, Ra ← Rb op Rc, Control_Signals = opcode[3:0]. Examples: shr=7, rol=10.
  - 12 (mul), 13 (div): HI/LO ← Rb op Rc, Control_Signals = 12 / 13.
  - 14 (neg), 15 (not): unary, Ra ← op Rb, Control_Signals = 14 / 15.
  - 16–31: illegal.
- T3:
  - Legal opcode: busSelect[Rb], enable[27]. Go to T4.
  - Illegal opcode: drive no bus/enable bits, pulse `illegal`, go to IDLE.
- T4: enable[24] and Control_Signals as decoded. Bus driver is busSelect[Rc] for binary and mul/div, busSelect[Rb] for unary. Go to T5.
- T5:
  - Binary/unary: busSelect[19], enable[Ra], `done`. Go to IDLE.
  - Mul/div: busSelect[19], enable[17]. Go to T6.
- T6: busSelect[18], enable[16], `done`. Go to IDLE.
- Invariants:
  - At most one busSelect bit is set in any state.
  - Ra, Rb, Rc may be equal; no special casing, R0 is writable.
  - `start` outside IDLE is ignored; there is no queuing.

## Timing
- Reset: `clr`=0 forces IDLE immediately, asynchronously, including mid-instruction. All outputs go to 0 in the same instant. An aborted instruction is simply abandoned, with no partial-state cleanup.
- Latency with `mem_rdy` already high in T1:
  - ALU/unary: `start` sampled at edge 0; T0–T5 occupy cycles 1–6; `done` in cycle 6; IDLE at cycle 7.
  - Mul/div: `done` in cycle 7.
- Each cycle spent in T1 with `mem_rdy`=0 adds exactly one cycle.
- Register loads occur at the rising edge that ends each state. Datapath registers capture the bus at that edge.
- `ir` must be stable from the end of T2 through the final state. It is the IR register, loaded at the T2 edge.
- Back-to-back: `start` high in the cycle after `done` launches the next T0 with no dead cycle beyond IDLE.

## Test plan
- Reset: hold `clr`=0 with random `start`/`ir` → all outputs 0, `busy`=0. Release with `start`=1 → T0 is the first cycle after the next edge.
- ROL: ir=32'h509A8000 (op 10, R1, R3, R5), `mem_rdy` tied 1. Expect:
  - T3: busSelect[3]+enable[27].
  - T4: busSelect[5]+enable[24] with Control_Signals=4'd10.
  - T5: busSelect[19]+enable[1] with `done`.
  - Total 6 busy cycles.
- Memory wait: shr ir=32'h389A8000 with `mem_rdy` low for 3 cycles in T1 → MD_Read+enable[21] held 4 cycles, `done` at cycle 9.
- Mul: opcode 12, Rb=2, Rc=4 → T5 enable[17]+busSelect[19], T6 enable[16]+busSelect[18]+`done`.
- Illegal: opcode 20 → `illegal` pulse in T3, no enable bits in T3, return to IDLE, `done` never asserted.
- Abort: drop `clr` during T4 → outputs 0 immediately. A new `start` after release runs a clean full sequence.
